// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back data-cache controller for the MEM stage
// Only the miss-handling state is registered; SRAM and memory controls are decoded each cycle.
module dcache_controller #(
  parameter int LINES  = 32,
  parameter int TAG_W  = 22,
  parameter int LINE_W = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      p1_req_i,
  input  logic                      p1_write_i,
  input  logic [31:0]               p1_addr_i,
  input  logic [31:0]               p1_data_i,
  output logic [31:0]               p1_data_o,
  output logic                      p1_stall_o,
  output logic                      tag_enable_o,
  output logic                      tag_write_o,
  output logic [$clog2(LINES)-1:0]  tag_addr_o,
  output logic [TAG_W+1:0]          tag_data_o,
  input  logic [TAG_W+1:0]          tag_data_i,
  output logic                      data_enable_o,
  output logic                      data_write_o,
  output logic [$clog2(LINES)-1:0]  data_addr_o,
  output logic [LINE_W-1:0]         data_data_o,
  input  logic [LINE_W-1:0]         data_data_i,
  output logic                      mem_enable_o,
  output logic                      mem_write_o,
  output logic [31:0]               mem_addr_o,
  output logic [LINE_W-1:0]         mem_data_o,
  input  logic                      mem_ack_i,
  input  logic [LINE_W-1:0]         mem_data_i
);
  localparam int OFF_W = 5;
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]  index;
  logic [2:0]        word;
  logic [TAG_W-1:0]  req_tag;
  logic              line_valid, line_dirty, hit, miss;
  logic [LINE_W-1:0] merged;
  logic              unused_ok;

  assign index      = p1_addr_i[OFF_W +: IDX_W];
  assign word       = p1_addr_i[4:2];
  assign req_tag    = p1_addr_i[31 -: TAG_W];
  assign line_valid = tag_data_i[TAG_W+1];
  assign line_dirty = tag_data_i[TAG_W];
  assign hit        = line_valid & (tag_data_i[TAG_W-1:0] == req_tag);
  assign miss       = p1_req_i & ~hit;
  assign tag_addr_o  = index;
  assign data_addr_o = index;
  assign unused_ok   = ^p1_addr_i[1:0];

  always_comb begin
    merged = data_data_i;
    merged[{word, 5'b0} +: 32] = p1_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    p1_stall_o    = 1'b1;
    p1_data_o     = '0;
    tag_enable_o  = 1'b1;
    tag_write_o   = 1'b0;
    tag_data_o    = {2'b10, req_tag};
    data_enable_o = 1'b1;
    data_write_o  = 1'b0;
    data_data_o   = mem_data_i;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    case (state_q)
      IDLE: begin
        tag_enable_o  = p1_req_i;
        data_enable_o = p1_req_i;
        p1_stall_o    = miss;
        if (!miss) p1_data_o = data_data_i[{word, 5'b0} +: 32];
        if (p1_req_i & hit & p1_write_i) begin
          tag_write_o  = 1'b1;
          tag_data_o   = {2'b11, req_tag};
          data_write_o = 1'b1;
          data_data_o  = merged;
        end
        if (miss) state_d = (line_valid & line_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        // The victim's tag and line stay readable here: nothing is written until refill.
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_data_i[TAG_W-1:0], index, {OFF_W{1'b0}}};
        mem_data_o   = data_data_i;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {p1_addr_i[31:OFF_W], {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          tag_write_o  = 1'b1;
          data_write_o = 1'b1;
          state_d      = REFILL;
        end
      end
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A write strobe while reset is held would corrupt a line mid-abort.
    if (!rst_i) begin
      tag_write_o  = 1'b0;
      data_write_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
// Bench owns the tag/data SRAMs and a latency-programmable main memory.
module tb_dcache_controller;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         p1_req_i = 1'b0, p1_write_i = 1'b0;
  logic [31:0]  p1_addr_i = '0, p1_data_i = '0, p1_data_o;
  logic         p1_stall_o;
  logic         tag_enable_o, tag_write_o, data_enable_o, data_write_o;
  logic [4:0]   tag_addr_o, data_addr_o;
  logic [23:0]  tag_data_o, tag_data_i;
  logic [255:0] data_data_o, data_data_i;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_i = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .tag_enable_o(tag_enable_o), .tag_write_o(tag_write_o), .tag_addr_o(tag_addr_o),
    .tag_data_o(tag_data_o), .tag_data_i(tag_data_i),
    .data_enable_o(data_enable_o), .data_write_o(data_write_o), .data_addr_o(data_addr_o),
    .data_data_o(data_data_o), .data_data_i(data_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  // SRAMs: combinational read, commit on negedge
  logic [23:0]  tag_mem  [32];
  logic [255:0] data_mem [32];
  logic         sram_clr = 1'b1;
  assign tag_data_i  = tag_mem[tag_addr_o];
  assign data_data_i = data_mem[data_addr_o];
  always @(negedge clk_i) begin
    if (sram_clr) begin
      for (int i = 0; i < 32; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (tag_enable_o && tag_write_o)   tag_mem[tag_addr_o]   <= tag_data_o;
      if (data_enable_o && data_write_o) data_mem[data_addr_o] <= data_data_o;
    end
  end

  // Main memory seen by the DUT, and the reference model's own copy
  logic [255:0] dram    [int unsigned];
  logic [255:0] ref_mem [int unsigned];
  logic         m_valid [32];
  logic         m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_line  [32];

  function automatic logic [255:0] dflt_line(int unsigned la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (la << 5) | (k << 2);
    return l;
  endfunction

  function automatic logic [255:0] dram_line(int unsigned la);
    return dram.exists(la) ? dram[la] : dflt_line(la);
  endfunction

  function automatic logic [255:0] ref_line(int unsigned la);
    return ref_mem.exists(la) ? ref_mem[la] : dflt_line(la);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                              input int lat, output logic [31:0] e_rd, output int e_stalls,
                              output logic e_wb, output logic [31:0] e_wb_addr,
                              output logic [255:0] e_wb_line);
    logic [4:0]  idx;
    logic [21:0] tg;
    int          w;
    logic        hit;
    idx = addr[9:5];
    tg  = addr[31:10];
    w   = int'(addr[4:2]);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    e_wb      = !hit && m_valid[idx] && m_dirty[idx];
    e_wb_addr = {m_tag[idx], idx, 5'b0};
    e_wb_line = m_line[idx];
    if (e_wb) ref_mem[{m_tag[idx], idx}] = m_line[idx];
    if (!hit) begin
      m_line[idx]  = ref_line(addr[31:5]);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    e_stalls = hit ? 0 : 2 + lat * (e_wb ? 2 : 1);
    e_rd     = m_line[idx][w*32 +: 32];
    if (wr) begin
      m_line[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic dut_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input int lat, output logic [31:0] rd, output int stalls,
                            output logic wb_seen, output logic [31:0] wb_addr,
                            output logic [255:0] wb_line, output logic proto_ok);
    int           cnt;
    logic         done;
    logic [31:0]  r_addr;
    logic         r_write;
    logic [255:0] r_data;
    p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = wd;
    stalls = 0; cnt = 0; done = 1'b0; rd = '0;
    wb_seen = 1'b0; wb_addr = '0; wb_line = '0; proto_ok = 1'b1;
    r_addr = '0; r_write = 1'b0; r_data = '0;
    for (int b = 0; b < 400 && !done; b++) begin
      #3;
      if (!p1_stall_o) begin
        rd   = p1_data_o;
        done = 1'b1;
      end else begin
        stalls++;
        if (p1_data_o !== 32'h0) proto_ok = 1'b0;
        if (mem_enable_o) begin
          if (cnt == 0) begin
            r_addr = mem_addr_o; r_write = mem_write_o; r_data = mem_data_o;
          end else if (mem_addr_o !== r_addr || mem_write_o !== r_write || mem_data_o !== r_data)
            proto_ok = 1'b0;
          if (mem_addr_o[4:0] != 5'd0) proto_ok = 1'b0;
          cnt++;
          if (cnt >= lat) begin
            mem_ack_i = 1'b1;
            if (mem_write_o) begin
              wb_seen = 1'b1; wb_addr = mem_addr_o; wb_line = mem_data_o;
              dram[mem_addr_o[31:5]] = mem_data_o;
              mem_data_i = '0;
            end else begin
              mem_data_i = dram_line(mem_addr_o[31:5]);
            end
            cnt = 0;
          end
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout: addr=%0h still stalled after 400 cycles", addr);
    end
  endtask

  task automatic run_op(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input logic use_tbl, input logic [31:0] t_rd,
                        input int t_stalls, input logic [23:0] t_tag);
    logic [31:0]  e_rd, rd, e_wb_addr, wb_addr;
    int           e_stalls, stalls;
    logic         e_wb, wb_seen, proto_ok;
    logic [255:0] e_wb_line, wb_line;
    logic [23:0]  e_tag;
    logic [4:0]   idx;
    idx = addr[9:5];
    model_access(wr, addr, wd, lat, e_rd, e_stalls, e_wb, e_wb_addr, e_wb_line);
    dut_access(wr, addr, wd, lat, rd, stalls, wb_seen, wb_addr, wb_line, proto_ok);
    @(posedge clk_i); #1;
    e_tag = {m_valid[idx], m_dirty[idx], m_tag[idx]};
    if (use_tbl) begin
      e_rd = t_rd; e_stalls = t_stalls; e_tag = t_tag;
    end
    if (!wr) check("load_data", rd, e_rd);
    check("stall_cycles", stalls, e_stalls);
    check("writeback_seen", wb_seen, e_wb);
    if (e_wb) begin
      check("writeback_addr", wb_addr, e_wb_addr);
      check("writeback_line", wb_line, e_wb_line);
    end
    check("mem_hold_and_stall_data", proto_ok, 1'b1);
    check("tag_sram", tag_mem[idx], e_tag);
    check("data_sram", data_mem[idx], m_line[idx]);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    int          stalls;
    logic [23:0] tag;
  } vec_t;

  vec_t         tbl [10];
  logic [23:0]  snap_tag;
  logic [255:0] snap_data, pre;
  logic [4:0]   idx_pool [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0404, 32'h0,         5,  32'hDEAD_BEEF, 7,  24'h800001};
    tbl[1] = '{1'b1, 32'h0000_0408, 32'h1234_5678, 5,  32'h0,         0,  24'hC00001};
    tbl[2] = '{1'b0, 32'h0000_0408, 32'h0,         5,  32'h1234_5678, 0,  24'hC00001};
    tbl[3] = '{1'b0, 32'h0000_0800, 32'h0,         3,  32'h0BAD_F00D, 8,  24'h800002};
    tbl[4] = '{1'b1, 32'h0000_0810, 32'hCAFE_F00D, 3,  32'h0,         0,  24'hC00002};
    tbl[5] = '{1'b0, 32'h0000_0C00, 32'h0,         20, 32'h0000_0C00, 42, 24'h800003};
    tbl[6] = '{1'b0, 32'h0000_0064, 32'h0,         2,  32'h0000_0064, 4,  24'h800000};
    tbl[7] = '{1'b0, 32'h0000_07E8, 32'h0,         2,  32'h0000_07E8, 4,  24'h800001};
    tbl[8] = '{1'b0, 32'h0000_0060, 32'h0,         1,  32'h0000_0060, 0,  24'h800000};
    tbl[9] = '{1'b0, 32'h0000_07FC, 32'h0,         1,  32'h0000_07FC, 0,  24'h800001};
    idx_pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};

    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
    end
    pre = dflt_line(32'h20); pre[63:32] = 32'hDEAD_BEEF;
    dram[32'h20] = pre; ref_mem[32'h20] = pre;
    pre = dflt_line(32'h40); pre[31:0] = 32'h0BAD_F00D;
    dram[32'h40] = pre; ref_mem[32'h40] = pre;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_mem_enable", mem_enable_o, 1'b0);
    check("rst_mem_write", mem_write_o, 1'b0);
    check("rst_tag_write", tag_write_o, 1'b0);
    check("rst_data_write", data_write_o, 1'b0);
    check("rst_idle_no_req_stall", p1_stall_o, 1'b0);
    check("rst_idle_no_req_tag_en", tag_enable_o, 1'b0);
    p1_req_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h404;
    #1;
    check("rst_req_miss_stall", p1_stall_o, 1'b1);
    check("rst_req_tag_write", tag_write_o, 1'b0);
    p1_req_i = 1'b0; p1_write_i = 1'b0;
    sram_clr = 1'b0;
    rst_i    = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat, 1'b1,
             tbl[i].rd, tbl[i].stalls, tbl[i].tag);
    p1_req_i = 1'b0;
    @(posedge clk_i); #1;

    // Reset pulsed during ALLOCATE, with a stray ack straddling it
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_00A0;
    snap_tag = tag_mem[5]; snap_data = data_mem[5];
    #3;
    check("abort_idle_stall", p1_stall_o, 1'b1);
    @(posedge clk_i); #1;
    check("abort_alloc_enable", mem_enable_o, 1'b1);
    check("abort_alloc_addr", mem_addr_o, 32'h0000_00A0);
    #1;
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = {8{32'h5A5A_5A5A}};
    #1;
    check("abort_enable_async", mem_enable_o, 1'b0);
    check("abort_tag_write", tag_write_o, 1'b0);
    check("abort_data_write", data_write_o, 1'b0);
    @(posedge clk_i); #1;
    p1_req_i = 1'b0; rst_i = 1'b1;
    #3;
    check("late_ack_enable", mem_enable_o, 1'b0);
    check("late_ack_stall", p1_stall_o, 1'b0);
    check("late_ack_data_write", data_write_o, 1'b0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    check("late_ack_still_idle", mem_enable_o, 1'b0);
    check("abort_tag_untouched", tag_mem[5], snap_tag);
    check("abort_data_untouched", data_mem[5], snap_data);
    run_op(1'b0, 32'h0000_00A0, 32'h0, 2, 1'b1, 32'h0000_00A0, 4, 24'h800000);

    // Randomized traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = {22'($urandom_range(0, 3)), idx_pool[$urandom_range(0, 4)],
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) begin
        p1_req_i = 1'b0;
        #3;
        check("gap_no_stall", p1_stall_o, 1'b0);
        check("gap_no_write", tag_write_o | data_write_o, 1'b0);
        @(posedge clk_i); #1;
      end
      run_op(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4),
             1'b0, 32'h0, 0, 24'h0);
    end
    p1_req_i = 1'b0;
    @(posedge clk_i); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Cache-side master that drives the 32-entry data-cache tag SRAM and its companion 32x256 data SRAM.
- Services CPU load/store requests to a direct-mapped, write-back, write-allocate cache with 32-byte lines.
- On a miss, runs write-back and refill transactions against data memory through an enable/ack handshake.
- Sits between the CPU MEM stage and data memory, and is the sole reader/writer of both cache SRAMs.

Parameters:
- LINES, 32, cache lines; index width is log2(LINES)=5.
- TAG_W, 22, stored address tag width.
- LINE_W, 256, line width in bits (8 words).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- p1_req_i  in  1  CPU access request, held until stall drops.
- p1_write_i  in  1  1=store, 0=load.
- p1_addr_i  in  32  byte address: tag [31:10], index [9:5], word [4:2], [1:0] ignored.
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data, valid when req and not stall.
- p1_stall_o  out  1  CPU must hold request.
- tag_enable_o, tag_write_o  out  1  tag SRAM controls.
- tag_addr_o  out  5  tag SRAM index.
- tag_data_o  out  24  {valid, dirty, tag[21:0]}.
- tag_data_i  in  24  tag SRAM combinational read data.
- data_enable_o, data_write_o  out  1  data SRAM controls.
- data_addr_o  out  5  data SRAM index.
- data_data_o  out  256  data SRAM write line.
- data_data_i  in  256  data SRAM combinational read line.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1=write-back, 0=fetch.
- mem_addr_o  out  32  line-aligned address, bits [4:0]=0.
- mem_data_o  out  256  write-back line.
- mem_ack_i  in  1  one-cycle completion pulse.
- mem_data_i  in  256  fetched line, valid with ack.

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE, REFILL. Only the state register, held at IDLE by rst_i=0, is sequential; all outputs are decoded from state and inputs.
- Reset values: mem_enable_o=0, mem_write_o=0, SRAM write strobes=0. p1_stall_o = p1_req_i & ~hit.
- SRAM enables equal p1_req_i in IDLE and 1 in other states. Addresses always use p1_addr_i[9:5].
- hit = tag_data_i[23] & (tag_data_i[21:0]==p1_addr_i[31:10]).
- IDLE read hit: zero extra cycles. p1_data_o = data_data_i word p1_addr_i[4:2], where word 0 = bits [31:0]. Stall=0.
- IDLE write hit: zero extra cycles, stall=0. data_write_o=1 with data_data_i and the selected word replaced by p1_data_i. tag_write_o=1 with {1,1,tag}. SRAMs commit on negedge.
- IDLE miss with req: stall=1. Next state is WRITEBACK if tag_data_i[23]&tag_data_i[22], else ALLOCATE.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={tag_data_i[21:0], index, 5'b0}, mem_data_o=data_data_i. Hold until mem_ack_i, then go to ALLOCATE.
- ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={p1_addr_i[31:5], 5'b0}. Hold until mem_ack_i.
- ALLOCATE, cycle of ack: data_write_o=1 with mem_data_i; tag_write_o=1 with {1,0,tag}; next state is REFILL.
- REFILL: stall=1, no writes; next state is IDLE. The access then resolves as a hit. A store sets dirty at that point.
- p1_stall_o=1 in every non-IDLE state. p1_data_o=0 whenever stall=1.
- mem_* request outputs hold constant while mem_enable_o=1; the request drops the cycle after ack.
- Memory latency is unbounded; ack outside WRITEBACK/ALLOCATE is ignored.
- Reset asserted mid-transaction: immediate return to IDLE, mem_enable_o=0 asynchronously. Any partial SRAM write is not performed. Memory must discard the request.
- p1_req_i=0 in IDLE: no SRAM writes, stall=0.

Test Plan:
- Cold read 0x0000_0404 (all tags invalid) -> stall, ALLOCATE to mem_addr 0x0000_0400. Memory returns line with word1=0xDEAD_BEEF after 5 cycles. Tag[0] written 0x800001. Stall drops next-but-one cycle with p1_data_o=0xDEAD_BEEF.
- Store 0x1234_5678 to 0x0000_0408 after refill -> no stall. Line[0] word2 updated; tag[0]=0xC00001.
- Load 0x0000_0800 (same index 0, tag 2, line dirty) -> WRITEBACK to 0x0000_0400 with dirty line. Then ALLOCATE at 0x0000_0800; tag[0]=0x800002.
- Ack delayed 20 cycles in WRITEBACK -> mem_* outputs stable all 20 cycles, stall held.
- rst_i pulsed low during ALLOCATE -> mem_enable_o=0 at once, state IDLE, tag/data SRAMs unmodified. Ack arriving after reset ignored.
- Read hit back-to-back on indices 3 and 31 -> zero stall cycles, correct words returned.
